// File: rtl/seg7_pkg.sv
// Shared types and constants for the scanned 7-segment display capture block.
// Latency: none (types and constants only).
// Backpressure: none.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // Glyph for hex value i sits at index i; bit6=a ... bit0=g, active-high.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

endpackage

// File: rtl/seg7_inv.sv
// Inverse 7-segment decoder: segment pattern -> hex nibble plus legal flag.
// Latency: combinational.
// Backpressure: none.
module seg7_inv
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = 4'd0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Reconstructs hex digits from a multiplexed 7-segment bus and snapshots full frames.
// Latency: capture STABLE_CYCLES+1 clocks after a new pattern first appears at the pins.
// Backpressure: none; the display bus is observed passively every cycle.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    input  logic [N_DIGITS-1:0]   an_in,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic [4*N_DIGITS-1:0] frame_hex,
    output logic                  frame_valid,
    output logic                  seg_err
);

    localparam logic [7:0] STB = 8'(STABLE_CYCLES);

    logic [6:0]            seg_r_q, seg_r_d;
    logic [N_DIGITS-1:0]   an_r_q, an_r_d;
    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [6:0]            pat_q, pat_d;
    logic [N_DIGITS-1:0]   an_lat_q, an_lat_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   dvld_q, dvld_d;
    logic [4*N_DIGITS-1:0] frame_q, frame_d;
    logic                  fvld_q, fvld_d;
    logic                  err_q, err_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;

    logic       samp_vld, found, multi, same, load, capture, legal;
    logic [3:0] nibble;

    seg7_inv u_inv (
        .seg    (seg_r_q),
        .nibble (nibble),
        .legal  (legal)
    );

    assign seg_r_d = seg_in;
    assign an_r_d  = an_in;

    // A sample is usable only when exactly one anode is driven low.
    always_comb begin
        found = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_r_q[i]) begin
                if (found) multi = 1'b1;
                found = 1'b1;
            end
        end
        samp_vld = found && !multi;
        same     = samp_vld && (an_r_q == an_lat_q) && (seg_r_q == pat_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r_q  <= '0;
            an_r_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            pat_q    <= '0;
            an_lat_q <= '0;
            digits_q <= '0;
            dvld_q   <= '0;
            frame_q  <= '0;
            fvld_q   <= 1'b0;
            err_q    <= 1'b0;
            seen_q   <= '0;
        end else begin
            seg_r_q  <= seg_r_d;
            an_r_q   <= an_r_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            an_lat_q <= an_lat_d;
            digits_q <= digits_d;
            dvld_q   <= dvld_d;
            frame_q  <= frame_d;
            fvld_q   <= fvld_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        an_lat_d = an_lat_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (samp_vld) load = 1'b1;
                else          cnt_d = '0;
            end
            SETTLE: begin
                if (!samp_vld) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (same) begin
                    cnt_d = (cnt_q >= STB) ? STB : cnt_q + 8'd1;
                end else begin
                    load = 1'b1;
                end
            end
            HELD: begin
                if (!samp_vld) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (load) begin
            state_d  = SETTLE;
            cnt_d    = 8'd1;
            pat_d    = seg_r_q;
            an_lat_d = an_r_q;
        end
        // With STABLE_CYCLES=1 a fresh load already satisfies the threshold.
        if (state_d == SETTLE && cnt_d == STB) state_d = HELD;
    end

    // Capture happens on any edge that enters HELD, including HELD->HELD via a reload.
    always_comb begin
        capture  = (state_d == HELD) && ((state_q != HELD) || load);
        digits_d = digits_q;
        dvld_d   = dvld_q;
        seen_d   = seen_q;
        frame_d  = frame_q;
        fvld_d   = 1'b0;
        err_d    = 1'b0;
        if (capture) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (!an_r_q[i]) begin
                    if (legal) digits_d[4*i +: 4] = nibble;
                    dvld_d[i] = legal;
                    seen_d[i] = 1'b1;
                end
            end
            err_d = !legal;
        end
        if (&seen_d) begin
            frame_d = digits_d;
            fvld_d  = 1'b1;
            seen_d  = '0;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = dvld_q;
    assign frame_hex   = frame_q;
    assign frame_valid = fvld_q;
    assign seg_err     = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus randomized scanning against a run-length model.
// Latency: model expects capture on the edge where an identical valid sample run reaches STABLE_CYCLES.
// Backpressure: none.
module tb_seg7_capture;

    localparam int N   = 8;
    localparam int STB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [6:0]      seg_in;
    logic [N-1:0]    an_in;
    logic [4*N-1:0]  digits;
    logic [N-1:0]    digit_valid;
    logic [4*N-1:0]  frame_hex;
    logic            frame_valid;
    logic            seg_err;

    int checks = 0;
    int errors = 0;
    int n_fv   = 0;
    int n_err  = 0;

    logic [6:0] gl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg7_capture #(.N_DIGITS(N), .STABLE_CYCLES(STB)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_hex   (frame_hex),
        .frame_valid (frame_valid),
        .seg_err     (seg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int glyph_val(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (gl[i] == p) return i;
        return -1;
    endfunction

    // Model: a digit is captured when the same valid (anode, pattern) sample has been
    // seen on exactly STB consecutive edges, one edge after it arrived at the pins.
    logic [6:0]     m_seg_r, last_seg;
    logic [N-1:0]   m_an_r, last_an, m_seen, m_dv;
    logic [4*N-1:0] m_digits, m_frame;
    logic           m_fv, m_err;
    int             run;

    always @(posedge clk) begin
        if (reset) begin
            m_seg_r = '0; m_an_r = '0; m_seen = '0; m_dv = '0;
            m_digits = '0; m_frame = '0; m_fv = 0; m_err = 0; run = 0;
            last_seg = '0; last_an = '0;
        end else begin
            int idx, g;
            logic vld;
            m_fv = 0;
            m_err = 0;
            vld = ($countones(~m_an_r) == 1);
            if (!vld) run = 0;
            else if (run > 0 && m_an_r == last_an && m_seg_r == last_seg) run++;
            else begin
                run = 1; last_an = m_an_r; last_seg = m_seg_r;
            end
            if (vld && run == STB) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (!m_an_r[i]) idx = i;
                g = glyph_val(m_seg_r);
                if (g >= 0) begin
                    m_digits[4*idx +: 4] = 4'(g);
                    m_dv[idx] = 1'b1;
                end else begin
                    m_dv[idx] = 1'b0;
                    m_err = 1;
                end
                m_seen[idx] = 1'b1;
                if (&m_seen) begin
                    m_frame = m_digits; m_fv = 1; m_seen = '0;
                end
            end
            m_seg_r = seg_in;
            m_an_r  = an_in;
        end
        #1;
        chk("digits", 64'(digits), 64'(m_digits));
        chk("digit_valid", 64'(digit_valid), 64'(m_dv));
        chk("frame_hex", 64'(frame_hex), 64'(m_frame));
        chk("frame_valid", 64'(frame_valid), 64'(m_fv));
        chk("seg_err", 64'(seg_err), 64'(m_err));
        if (frame_valid === 1'b1) n_fv++;
        if (seg_err === 1'b1) n_err++;
    end

    task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input int d, input logic [6:0] seg, input int n);
        logic [N-1:0] an;
        an = '1;
        an[d] = 1'b0;
        hold(an, seg, n);
    endtask

    initial begin
        int fv0, err0;
        reset  = 1'b1;
        an_in  = '1;
        seg_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_digits", 64'(digits), 64'h0);
        chk("rst_dvld", 64'(digit_valid), 64'h0);
        chk("rst_frame", 64'(frame_hex), 64'h0);
        chk("rst_fv", 64'(frame_valid), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Stable digit: capture on the 5th edge, not before.
        hold(8'hFE, 7'h6D, 4);
        chk("stable_pre_dv0", 64'(digit_valid[0]), 64'h0);
        hold(8'hFE, 7'h6D, 1);
        chk("stable_dv0", 64'(digit_valid[0]), 64'h1);
        chk("stable_d0", 64'(digits[3:0]), 64'h2);
        hold(8'hFE, 7'h6D, 1);
        hold(8'hFF, 7'h00, 2);

        // Glitch: 8 must never land in digit 1.
        hold(8'hFD, 7'h7F, 2);
        hold(8'hFD, 7'h7B, 4);
        chk("glitch_pre_d1", 64'(digits[7:4]), 64'h0);
        hold(8'hFD, 7'h7B, 1);
        chk("glitch_d1", 64'(digits[7:4]), 64'h9);
        hold(8'hFF, 7'h00, 2);

        // Illegal pattern.
        err0 = n_err;
        hold(8'hFB, 7'h00, 5);
        chk("illegal_err_pulse", 64'(seg_err), 64'h1);
        hold(8'hFB, 7'h00, 1);
        chk("illegal_err_drop", 64'(seg_err), 64'h0);
        chk("illegal_err_count", 64'(n_err - err0), 64'h1);
        chk("illegal_dv2", 64'(digit_valid[2]), 64'h0);
        chk("illegal_d2", 64'(digits[11:8]), 64'h0);
        hold(8'hFF, 7'h00, 2);

        // Anode fault: two anodes low never capture.
        hold(8'hFC, 7'h30, 10);
        chk("anode_dv", 64'(digit_valid), 64'h03);
        chk("anode_digits", 64'(digits), 64'h0000_0092);
        hold(8'hFF, 7'h00, 2);

        // Full frame.
        fv0 = n_fv;
        for (int d = 0; d < 8; d++) begin
            scan(d, gl[d+1], 5);
            if (d == 7) begin
                chk("frame_pulse", 64'(frame_valid), 64'h1);
                chk("frame_hex", 64'(frame_hex), 64'h8765_4321);
            end
        end
        chk("frame_count", 64'(n_fv - fv0), 64'h1);
        chk("frame_dvld", 64'(digit_valid), 64'hFF);
        hold(8'hFF, 7'h00, 2);

        // Reset mid-frame.
        for (int d = 0; d < 6; d++) scan(d, gl[d+10], 5);
        an_in = '1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_digits", 64'(digits), 64'h0);
        chk("mid_rst_dvld", 64'(digit_valid), 64'h0);
        chk("mid_rst_frame", 64'(frame_hex), 64'h0);
        chk("mid_rst_fv", 64'(frame_valid), 64'h0);
        chk("mid_rst_err", 64'(seg_err), 64'h0);
        fv0 = n_fv;
        scan(6, gl[14], 5);
        scan(7, gl[15], 5);
        chk("post_rst_no_frame", 64'(n_fv - fv0), 64'h0);
        for (int d = 0; d < 6; d++) scan(d, gl[d], 5);
        chk("post_rst_frame_pulse", 64'(frame_valid), 64'h1);
        chk("post_rst_frame_hex", 64'(frame_hex), 64'hFE54_3210);
        hold(8'hFF, 7'h00, 2);

        // Randomized scanning; the model checks every cycle.
        for (int k = 0; k < 400; k++) begin
            int r, d;
            logic [N-1:0] an;
            logic [6:0] seg;
            r = int'($urandom_range(0, 39));
            if (r == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
            end else begin
                d = int'($urandom_range(0, N-1));
                an = '1;
                if (r < 34) an[d] = 1'b0;
                else if (r < 37) an = 8'($urandom);
                seg = ($urandom_range(0, 9) < 8) ? gl[$urandom_range(0, 15)] : 7'($urandom);
                hold(an, seg, int'($urandom_range(1, 7)));
            end
        end
        hold(8'hFF, 7'h00, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
